dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port round-robin arbiter and sequencer in front of the 32×8 data memory.

- Port 0 is the CPU load/store path; port 1 is the loader/DMA path.
- Each cycle it selects at most one requester and drives that requester's command onto the memory command bus (`mem_addr`, `mem_wdata`, `MemRead`, `MemWrite`).
- It routes the registered read data back to whichever port issued the read.
- It supports short locked bursts, with a forced-release limit so neither port starves.

## Interface

Parameters:
- `ADDR_W`, 8: address width; matches the memory address bus.
- `DATA_W`, 8: data width.
- `MAX_LOCK`, 4: maximum consecutive grants to a locked owner before the lock is forcibly broken.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `RST`  in  1: reset, synchronous and active-low (0 = reset, sampled at `posedge clk`).
- `pN_req`  in  1: port N (N = 0, 1) has a command pending; held until granted.
- `pN_we`  in  1: 1 = write, 0 = read.
- `pN_lock`  in  1: requests that ownership be kept after this grant.
- `pN_addr`  in  `ADDR_W`: port N address.
- `pN_wdata`  in  `DATA_W`: port N write data.
- `pN_gnt`  out  1: command accepted this cycle (combinational).
- `pN_rvalid`  out  1: read data for port N valid this cycle (registered).
- `pN_rdata`  out  `DATA_W`: equals `memReadData` when `pN_rvalid`=1, else 0.
- `mem_addr`  out  `ADDR_W`: memory address.
- `mem_wdata`  out  `DATA_W`: memory write data.
- `MemRead`  out  1: memory read strobe.
- `MemWrite`  out  1: memory write strobe.
- `memReadData`  in  `DATA_W`: registered memory read data; valid one cycle after `MemRead`.

## Operation

**FSM states:** IDLE, LOCK0, LOCK1. Reset state is IDLE.

**Grant selection, IDLE:**
- Only one port requests: that port wins.
- Both request: the port other than `last` wins.
- `last` resets to 1, so port 0 wins the first tie.
- `last` updates to the winner on every grant.

**Grant selection, LOCKn:**
- Only port n can be granted.
- The other port's request is held off; its `gnt`=0.

**Transitions on a grant to port n:**
- Enter or stay in LOCKn if `pn_lock`=1 and `lock_cnt`+1 < `MAX_LOCK`.
- Otherwise go to IDLE.

**Other transitions:**
- LOCKn with `pn_req`=0: go to IDLE. No grant is issued this cycle; the other port is considered next cycle.
- Forced release at `MAX_LOCK`: return to IDLE with `last`=n, so the other port wins any tie next cycle.

**`lock_cnt`:**
- 3-bit counter of consecutive grants in the current lock.
- Set to 1 when a lock is entered.
- Increments on each grant to the owner while locked.
- Cleared to 0 in IDLE.

**Command drive:**
- With no grant: `MemRead`=`MemWrite`=0, and `mem_addr`/`mem_wdata` hold their previous values.
- With a grant to port n, `mem_addr`=`pn_addr` and `mem_wdata`=`pn_wdata`.
- `MemWrite`=`pn_we` and `MemRead`=`!pn_we`.
- Exactly one strobe is high per grant.

**Read return:**
- Register `rsel` (winner id) and `rpend` (=1 for a granted read).
- Next cycle, assert `p[rsel]_rvalid` for one cycle.
- Writes produce no `rvalid`.

## Timing

**Reset values** (while `RST`=0):
- Outputs: `pN_gnt`=0, `pN_rvalid`=0, `pN_rdata`=0, `MemRead`=`MemWrite`=0, `mem_addr`=0, `mem_wdata`=0.
- Internal state: IDLE, `last`=1, `lock_cnt`=0, `rpend`=0.

**Latency:**
- Grant is issued in the same cycle as the request, if eligible.
- A write commits at the next `posedge`.
- Read data appears with `rvalid` exactly one cycle after the granted cycle.

**Throughput:** one access per cycle. Back-to-back reads are allowed; each read's `rvalid` is pipelined one cycle behind its grant.

**Boundary cases:**
- Simultaneous `req` from both ports in IDLE resolves by `last`. Both `gnt` are never high in the same cycle.
- Reset asserted the cycle after a read grant: `rvalid` stays 0 (pending read dropped). Any lock is discarded.
- `req` deasserted without a grant is legal; no state change.
- `MAX_LOCK`=1 disables locking entirely (always IDLE).

## Structure

**Shared package (`dmem_pkg`):**
- State encoding: IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2.
- Port id constants: `PORT_CPU`=0, `PORT_DMA`=1.
- Default `ADDR_W`/`DATA_W`, also used by the memory and the CPU datapath.

**Sub-module:** one, `rr_pick2`. It is combinational and takes `req[1:0]` and `last`, returning a one-hot `win[1:0]`. The FSM, counter and return pipeline stay in the top module.

## Test plan

- **Reset:** hold `RST`=0 for 3 cycles with both `req`=1 → all `gnt`, strobes and `rvalid` are 0. Release → port 0 granted in the first cycle.
- **Tie round-robin:** both ports request reads continuously at addresses 0x03 / 0x12 → grants alternate 0,1,0,1. Each `rvalid` lands on the correct port one cycle later with data 0x03 / 0xFE.
- **Write then read:** port 1 writes 0xA5 to 0x07, then reads 0x07 → `MemWrite` pulses once. The read returns 0xA5 on `p1_rdata` with `p1_rvalid` one cycle after the read grant.
- **Lock and forced release:** `p0_lock`=1 and `p0_req`=1 continuously, `p1_req`=1 → port 0 receives exactly 4 consecutive grants. Port 1 is granted on the 5th cycle.
- **Lock drop:** port 0 locks and then deasserts `req` after 2 grants → idle cycle, then port 1 granted next cycle. `lock_cnt` returns to 0.
- **Reset mid-read:** port 0 read granted at cycle t, `RST`=0 at t+1 → `p0_rvalid` stays 0 at t+1 and after.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_pkg: shared types and constants for the data-memory subsystem   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 8;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick2: two-way round-robin pick; on a tie the port != last wins   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_arbiter: two-port round-robin arbiter with locked bursts and    |
// | read-data return routing in front of the data memory.  Rev 1.0       |
// +----------------------------------------------------------------------+
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = DMEM_ADDR_W,
  parameter int DATA_W   = DMEM_DATA_W,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] memReadData
);

  arb_state_e        state_q, state_d;
  logic              last_q, last_d;
  logic [2:0]        lock_cnt_q, lock_cnt_d;
  logic              rpend_q, rpend_d;
  logic              rsel_q, rsel_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [1:0]        rr_win;
  logic [1:0]        gnt;
  logic              granted;
  logic              win_id;
  logic              win_we;
  logic              win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_pick2 u_pick (
    .req  ({p1_req, p0_req}),
    .last (last_q),
    .win  (rr_win)
  );

  always_comb begin
    gnt        = 2'b00;
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;

    unique case (state_q)
      IDLE: begin
        gnt        = rr_win;
        lock_cnt_d = 3'd0;
      end
      LOCK0: begin
        if (p0_req) begin
          gnt = 2'b01;
        end else begin
          state_d    = IDLE;
          lock_cnt_d = 3'd0;
        end
      end
      LOCK1: begin
        if (p1_req) begin
          gnt = 2'b10;
        end else begin
          state_d    = IDLE;
          lock_cnt_d = 3'd0;
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = 3'd0;
      end
    endcase

    // Nothing may reach the memory bus while reset is held.
    if (!RST) gnt = 2'b00;

    granted   = |gnt;
    win_id    = gnt[1] ? PORT_DMA : PORT_CPU;
    win_we    = (win_id == PORT_DMA) ? p1_we    : p0_we;
    win_lock  = (win_id == PORT_DMA) ? p1_lock  : p0_lock;
    win_addr  = (win_id == PORT_DMA) ? p1_addr  : p0_addr;
    win_wdata = (win_id == PORT_DMA) ? p1_wdata : p0_wdata;

    // lock_cnt is 0 in IDLE, so entering a lock naturally sets it to 1.
    if (granted) begin
      last_d = win_id;
      if (win_lock && ((int'(lock_cnt_q) + 1) < MAX_LOCK)) begin
        state_d    = (win_id == PORT_DMA) ? LOCK1 : LOCK0;
        lock_cnt_d = lock_cnt_q + 3'd1;
      end else begin
        state_d    = IDLE;
        lock_cnt_d = 3'd0;
      end
    end

    rpend_d     = granted && !win_we;
    rsel_d      = granted ? win_id : rsel_q;
    mem_addr_d  = granted ? win_addr : mem_addr_q;
    mem_wdata_d = granted ? win_wdata : mem_wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      lock_cnt_q  <= 3'd0;
      rpend_q     <= 1'b0;
      rsel_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      lock_cnt_q  <= lock_cnt_d;
      rpend_q     <= rpend_d;
      rsel_q      <= rsel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign MemRead   = granted && !win_we;
  assign MemWrite  = granted && win_we;
  assign mem_addr  = !RST ? '0 : mem_addr_d;
  assign mem_wdata = !RST ? '0 : mem_wdata_d;

  // A read issued just before reset is dropped rather than returned.
  assign p0_rvalid = RST && rpend_q && (rsel_q == PORT_CPU);
  assign p1_rvalid = RST && rpend_q && (rsel_q == PORT_DMA);
  assign p0_rdata  = p0_rvalid ? memReadData : '0;
  assign p1_rdata  = p1_rvalid ? memReadData : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_arbiter: directed self-checking bench with a 32x8 memory     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dmem_arbiter;

  logic       clk;
  logic       RST;
  logic       p0_req, p0_we, p0_lock;
  logic [7:0] p0_addr, p0_wdata;
  logic       p0_gnt, p0_rvalid;
  logic [7:0] p0_rdata;
  logic       p1_req, p1_we, p1_lock;
  logic [7:0] p1_addr, p1_wdata;
  logic       p1_gnt, p1_rvalid;
  logic [7:0] p1_rdata;
  logic [7:0] mem_addr, mem_wdata;
  logic       MemRead, MemWrite;
  logic [7:0] memReadData;

  logic [7:0] mem [0:31];
  int         n_tests;
  int         n_fail;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_LOCK(4)) dut (
    .clk         (clk),
    .RST         (RST),
    .p0_req      (p0_req),
    .p0_we       (p0_we),
    .p0_lock     (p0_lock),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p0_gnt      (p0_gnt),
    .p0_rvalid   (p0_rvalid),
    .p0_rdata    (p0_rdata),
    .p1_req      (p1_req),
    .p1_we       (p1_we),
    .p1_lock     (p1_lock),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_gnt      (p1_gnt),
    .p1_rvalid   (p1_rvalid),
    .p1_rdata    (p1_rdata),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .memReadData (memReadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: synchronous write, registered read.
  always @(posedge clk) begin
    if (MemWrite) mem[mem_addr[4:0]] <= mem_wdata;
    if (MemRead)  memReadData <= mem[mem_addr[4:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_cyc(input string tag, input logic g0, input logic g1,
                           input logic rd, input logic wr, input logic v0, input logic v1);
    check_eq({tag, " p0_gnt"}, p0_gnt, g0);
    check_eq({tag, " p1_gnt"}, p1_gnt, g1);
    check_eq({tag, " MemRead"}, MemRead, rd);
    check_eq({tag, " MemWrite"}, MemWrite, wr);
    check_eq({tag, " p0_rvalid"}, p0_rvalid, v0);
    check_eq({tag, " p1_rvalid"}, p1_rvalid, v1);
  endtask

  // Inputs change on the falling edge; checks happen 1ns before the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #4;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    mem[5'h12] = 8'hFE;
    memReadData = 8'h00;

    RST = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = 8'h03; p0_wdata = 8'h00;
    p1_req = 1'b1; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = 8'h12; p1_wdata = 8'h00;

    // Reset held with both ports requesting
    for (int i = 0; i < 3; i++) begin
      step(); settle();
      check_cyc("reset", 0, 0, 0, 0, 0, 0);
      check_eq("reset mem_addr", mem_addr, 8'h00);
      check_eq("reset p0_rdata", p0_rdata, 8'h00);
    end

    // Tie round-robin: 0,1,0,1 with returns one cycle behind
    step(); RST = 1'b1; settle();
    check_cyc("rr0", 1, 0, 1, 0, 0, 0);
    check_eq("rr0 mem_addr", mem_addr, 8'h03);
    step(); settle();
    check_cyc("rr1", 0, 1, 1, 0, 1, 0);
    check_eq("rr1 mem_addr", mem_addr, 8'h12);
    check_eq("rr1 p0_rdata", p0_rdata, 8'h03);
    step(); settle();
    check_cyc("rr2", 1, 0, 1, 0, 0, 1);
    check_eq("rr2 p1_rdata", p1_rdata, 8'hFE);
    step(); settle();
    check_cyc("rr3", 0, 1, 1, 0, 1, 0);
    check_eq("rr3 p0_rdata", p0_rdata, 8'h03);
    step(); p0_req = 1'b0; p1_req = 1'b0; settle();
    check_cyc("rr4", 0, 0, 0, 0, 0, 1);
    check_eq("rr4 p1_rdata", p1_rdata, 8'hFE);
    check_eq("rr4 mem_addr hold", mem_addr, 8'h12);
    check_eq("rr4 p0_rdata", p0_rdata, 8'h00);

    // Port 1 write 0xA5 to 0x07, then read it back
    step(); p1_req = 1'b1; p1_we = 1'b1; p1_addr = 8'h07; p1_wdata = 8'hA5; settle();
    check_cyc("wr", 0, 1, 0, 1, 0, 0);
    check_eq("wr mem_addr", mem_addr, 8'h07);
    check_eq("wr mem_wdata", mem_wdata, 8'hA5);
    step(); p1_we = 1'b0; settle();
    check_cyc("rd", 0, 1, 1, 0, 0, 0);
    step(); p1_req = 1'b0; settle();
    check_cyc("rd ret", 0, 0, 0, 0, 0, 1);
    check_eq("rd p1_rdata", p1_rdata, 8'hA5);
    check_eq("rd mem_wdata hold", mem_wdata, 8'hA5);

    // Lock: port 0 gets exactly 4 grants, then port 1
    step(); p0_req = 1'b1; p0_lock = 1'b1; p0_addr = 8'h03; p1_req = 1'b1; p1_addr = 8'h12;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("lock p0_gnt", p0_gnt, 1'b1);
      check_eq("lock p1_gnt", p1_gnt, 1'b0);
      step();
    end
    settle();
    check_eq("release p0_gnt", p0_gnt, 1'b0);
    check_eq("release p1_gnt", p1_gnt, 1'b1);
    check_eq("release p0_rvalid", p0_rvalid, 1'b1);
    step(); p0_req = 1'b0; p0_lock = 1'b0; p1_req = 1'b0; settle();
    check_cyc("release ret", 0, 0, 0, 0, 0, 1);

    // Lock drop after 2 grants
    step(); p0_req = 1'b1; p0_lock = 1'b1; p1_req = 1'b1; settle();
    check_cyc("drop g1", 1, 0, 1, 0, 0, 0);
    step(); settle();
    check_cyc("drop g2", 1, 0, 1, 0, 1, 0);
    step(); p0_req = 1'b0; settle();
    check_cyc("drop idle", 0, 0, 0, 0, 1, 0);
    step(); settle();
    check_cyc("drop p1", 0, 1, 1, 0, 0, 0);
    // A fresh lock must again allow a full burst of 4, so the count restarted
    step(); p0_req = 1'b1; settle();
    for (int i = 0; i < 4; i++) begin
      check_eq("relock p0_gnt", p0_gnt, 1'b1);
      check_eq("relock p1_gnt", p1_gnt, 1'b0);
      step(); settle();
    end
    check_eq("relock release p1_gnt", p1_gnt, 1'b1);
    check_eq("relock release p0_gnt", p0_gnt, 1'b0);
    step(); p0_req = 1'b0; p0_lock = 1'b0; p1_req = 1'b0; settle();
    check_cyc("relock ret", 0, 0, 0, 0, 0, 1);

    // Reset the cycle after a read grant drops the return
    step(); p0_req = 1'b1; p0_addr = 8'h03; settle();
    check_cyc("mid t", 1, 0, 1, 0, 0, 0);
    step(); RST = 1'b0; p0_req = 1'b0; settle();
    check_cyc("mid t+1", 0, 0, 0, 0, 0, 0);
    check_eq("mid t+1 p0_rdata", p0_rdata, 8'h00);
    step(); settle();
    check_cyc("mid t+2", 0, 0, 0, 0, 0, 0);
    step(); RST = 1'b1; settle();
    check_cyc("mid after", 0, 0, 0, 0, 0, 0);
    // last returns to 1 after reset: port 0 wins the next tie
    step(); p0_req = 1'b1; p1_req = 1'b1; settle();
    check_cyc("post reset tie", 1, 0, 1, 0, 0, 0);
    step(); p0_req = 1'b0; p1_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
